// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - two-requester arbiter sharing one external barrel shifter
module shift_arbiter #(
    parameter int FIXED_PRIO = 0,
    parameter int SA_BITS    = 5
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        r0_valid,
    output logic        r0_ready,
    input  logic [31:0] r0_d,
    input  logic [31:0] r0_sa,
    input  logic        r0_right,
    input  logic        r0_arith,
    input  logic        r1_valid,
    output logic        r1_ready,
    input  logic [31:0] r1_d,
    input  logic [31:0] r1_sa,
    input  logic        r1_right,
    input  logic        r1_arith,
    output logic [31:0] sh_d,
    output logic [31:0] sh_sa,
    output logic        sh_right,
    output logic        sh_arith,
    input  logic [31:0] sh_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_src,
    output logic [7:0]  busy_cnt
);

    localparam logic [31:0] SA_MASK = (SA_BITS >= 32) ? 32'hFFFF_FFFF
                                                      : ((32'd1 << SA_BITS) - 32'd1);

    logic        out_valid_q, out_valid_d;
    logic [31:0] out_result_q, out_result_d;
    logic        out_src_q, out_src_d;
    logic [7:0]  busy_cnt_q, busy_cnt_d;
    logic        last_gnt_q, last_gnt_d;

    logic free;
    logic both;
    logic gnt;
    logic accept;

    always_comb begin
        free = !out_valid_q | out_ready;
        both = r0_valid & r1_valid;
        gnt  = 1'b0;
        if (both) begin
            gnt = (FIXED_PRIO != 0) ? 1'b0 : ~last_gnt_q;
        end else if (r1_valid) begin
            gnt = 1'b1;
        end
        // Readies are gated by clrn so nothing is accepted while reset is held.
        r0_ready = clrn & free & ~gnt & r0_valid;
        r1_ready = clrn & free &  gnt & r1_valid;
        accept   = r0_ready | r1_ready;
    end

    always_comb begin
        if (gnt) begin
            sh_d     = r1_d;
            sh_sa    = r1_sa & SA_MASK;
            sh_right = r1_right;
            sh_arith = r1_arith;
        end else begin
            sh_d     = r0_d;
            sh_sa    = r0_sa & SA_MASK;
            sh_right = r0_right;
            sh_arith = r0_arith;
        end
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_src_d    = out_src_q;
        last_gnt_d   = last_gnt_q;
        busy_cnt_d   = busy_cnt_q;
        if (accept) begin
            out_valid_d  = 1'b1;
            out_result_d = sh_result;
            out_src_d    = gnt;
            if (both) begin
                last_gnt_d = gnt;
            end
        end else if (out_valid_q & out_ready) begin
            out_valid_d = 1'b0;
        end
        if ((r0_valid | r1_valid) & !free & (busy_cnt_q != 8'hFF)) begin
            busy_cnt_d = busy_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            out_valid_q  <= 1'b0;
            out_result_q <= 32'd0;
            out_src_q    <= 1'b0;
            busy_cnt_q   <= 8'd0;
            last_gnt_q   <= 1'b1;
        end else begin
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_src_q    <= out_src_d;
            busy_cnt_q   <= busy_cnt_d;
            last_gnt_q   <= last_gnt_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_src    = out_src_q;
    assign busy_cnt   = busy_cnt_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// tb/tb_shift_arbiter.sv - directed bench for shift_arbiter (round-robin and fixed-priority)
module tb_shift_arbiter;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        r0_valid = 1'b0, r1_valid = 1'b0;
    logic [31:0] r0_d = 32'd0, r0_sa = 32'd0, r1_d = 32'd0, r1_sa = 32'd0;
    logic        r0_right = 1'b0, r0_arith = 1'b0, r1_right = 1'b0, r1_arith = 1'b0;
    logic        out_ready = 1'b0;

    logic        r0_ready, r1_ready, sh_right, sh_arith, out_valid, out_src;
    logic [31:0] sh_d, sh_sa, sh_result, out_result;
    logic [7:0]  busy_cnt;

    logic        fp_r0_ready, fp_r1_ready, fp_sh_right, fp_sh_arith, fp_out_valid, fp_out_src;
    logic [31:0] fp_sh_d, fp_sh_sa, fp_sh_result, fp_out_result;
    logic [7:0]  fp_busy_cnt;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // Reference barrel shifter; uses the full 32-bit amount so unmasked upper bits would show.
    function automatic logic [31:0] shf(input logic [31:0] d, input logic [31:0] sa,
                                        input logic right, input logic arith);
        if (sa >= 32) return (right && arith && d[31]) ? 32'hFFFF_FFFF : 32'd0;
        if (!right) return d << sa[4:0];
        if (arith) return $unsigned($signed(d) >>> sa[4:0]);
        return d >> sa[4:0];
    endfunction

    assign sh_result    = shf(sh_d, sh_sa, sh_right, sh_arith);
    assign fp_sh_result = shf(fp_sh_d, fp_sh_sa, fp_sh_right, fp_sh_arith);

    shift_arbiter #(.FIXED_PRIO(0), .SA_BITS(5)) dut (
        .clk(clk), .clrn(clrn),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_d(r0_d), .r0_sa(r0_sa),
        .r0_right(r0_right), .r0_arith(r0_arith),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_d(r1_d), .r1_sa(r1_sa),
        .r1_right(r1_right), .r1_arith(r1_arith),
        .sh_d(sh_d), .sh_sa(sh_sa), .sh_right(sh_right), .sh_arith(sh_arith),
        .sh_result(sh_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_src(out_src), .busy_cnt(busy_cnt)
    );

    shift_arbiter #(.FIXED_PRIO(1), .SA_BITS(5)) dut_fp (
        .clk(clk), .clrn(clrn),
        .r0_valid(r0_valid), .r0_ready(fp_r0_ready), .r0_d(r0_d), .r0_sa(r0_sa),
        .r0_right(r0_right), .r0_arith(r0_arith),
        .r1_valid(r1_valid), .r1_ready(fp_r1_ready), .r1_d(r1_d), .r1_sa(r1_sa),
        .r1_right(r1_right), .r1_arith(r1_arith),
        .sh_d(fp_sh_d), .sh_sa(fp_sh_sa), .sh_right(fp_sh_right), .sh_arith(fp_sh_arith),
        .sh_result(fp_sh_result),
        .out_valid(fp_out_valid), .out_ready(out_ready), .out_result(fp_out_result),
        .out_src(fp_out_src), .busy_cnt(fp_busy_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        clrn = 1'b0;
        step();
        step();
        clrn = 1'b1;
    endtask

    task automatic test_reset();
        r0_valid = 1'b1;
        r1_valid = 1'b1;
        step();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        vectors++; if (out_result !== 32'd0) begin miscompares++; $display("FAIL reset_out_result got=%h exp=0", out_result); end
        vectors++; if (out_src !== 1'b0) begin miscompares++; $display("FAIL reset_out_src got=%b exp=0", out_src); end
        vectors++; if (busy_cnt !== 8'd0) begin miscompares++; $display("FAIL reset_busy_cnt got=%0d exp=0", busy_cnt); end
        vectors++; if ({r0_ready, r1_ready} !== 2'b00) begin miscompares++; $display("FAIL reset_readys got=%b exp=00", {r0_ready, r1_ready}); end
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        step();
        clrn = 1'b1;
    endtask

    task automatic test_single();
        r0_valid = 1'b1; r0_d = 32'h8000_0000; r0_sa = 32'd4; r0_right = 1'b1; r0_arith = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        vectors++; if ({r0_ready, r1_ready} !== 2'b10) begin miscompares++; $display("FAIL single_ready got=%b exp=10", {r0_ready, r1_ready}); end
        vectors++; if (sh_sa !== 32'd4) begin miscompares++; $display("FAIL single_sh_sa got=%h exp=4", sh_sa); end
        step();
        r0_valid = 1'b0;
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL single_out_valid got=%b exp=1", out_valid); end
        vectors++; if (out_result !== 32'hF800_0000) begin miscompares++; $display("FAIL single_result got=%h exp=f8000000", out_result); end
        vectors++; if (out_src !== 1'b0) begin miscompares++; $display("FAIL single_src got=%b exp=0", out_src); end
        step();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single_consume got=%b exp=0", out_valid); end
        vectors++; if (out_result !== 32'hF800_0000) begin miscompares++; $display("FAIL single_hold got=%h exp=f8000000", out_result); end
    endtask

    task automatic test_back_to_back();
        r0_valid = 1'b1; r0_d = 32'h0000_00F0; r0_sa = 32'd4; r0_right = 1'b1; r0_arith = 1'b0;
        r1_valid = 1'b1; r1_d = 32'h0000_00FF; r1_sa = 32'd8; r1_right = 1'b0; r1_arith = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        vectors++; if ({r0_ready, r1_ready} !== 2'b10) begin miscompares++; $display("FAIL b2b_first_gnt got=%b exp=10", {r0_ready, r1_ready}); end
        step();
        r0_valid = 1'b0;
        vectors++; if (out_result !== 32'h0000_000F) begin miscompares++; $display("FAIL b2b_r0_result got=%h exp=0000000f", out_result); end
        vectors++; if (out_src !== 1'b0) begin miscompares++; $display("FAIL b2b_r0_src got=%b exp=0", out_src); end
        @(negedge clk);
        vectors++; if ({r0_ready, r1_ready} !== 2'b01) begin miscompares++; $display("FAIL b2b_second_gnt got=%b exp=01", {r0_ready, r1_ready}); end
        step();
        r1_valid = 1'b0;
        vectors++; if (out_result !== 32'h0000_FF00) begin miscompares++; $display("FAIL b2b_r1_result got=%h exp=0000ff00", out_result); end
        vectors++; if ({out_valid, out_src} !== 2'b11) begin miscompares++; $display("FAIL b2b_r1_valid_src got=%b exp=11", {out_valid, out_src}); end
        step();
    endtask

    task automatic test_alternate();
        pulse_reset();
        r0_valid = 1'b1; r0_d = 32'h0000_0001; r0_sa = 32'd1; r0_right = 1'b0; r0_arith = 1'b0;
        r1_valid = 1'b1; r1_d = 32'h0000_0010; r1_sa = 32'd1; r1_right = 1'b1; r1_arith = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            vectors++; if (r0_ready !== (i % 2 == 0) || r1_ready !== (i % 2 == 1)) begin
                miscompares++; $display("FAIL rr_gnt[%0d] got=%b%b exp_r1=%0d", i, r0_ready, r1_ready, i % 2); end
            vectors++; if ({fp_r0_ready, fp_r1_ready} !== 2'b10) begin
                miscompares++; $display("FAIL fp_gnt[%0d] got=%b exp=10", i, {fp_r0_ready, fp_r1_ready}); end
            step();
            vectors++; if (out_src !== 1'(i % 2) || out_result !== ((i % 2 == 0) ? 32'd2 : 32'd8)) begin
                miscompares++; $display("FAIL rr_result[%0d] got=%b/%h exp_src=%0d", i, out_src, out_result, i % 2); end
            vectors++; if (fp_out_src !== 1'b0 || fp_out_result !== 32'd2) begin
                miscompares++; $display("FAIL fp_result[%0d] got=%b/%h exp=0/00000002", i, fp_out_src, fp_out_result); end
        end
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        step();
    endtask

    task automatic test_stall();
        pulse_reset();
        out_ready = 1'b0;
        r0_valid = 1'b1; r0_d = 32'h8000_0001; r0_sa = 32'd0; r0_right = 1'b1; r0_arith = 1'b1;
        step();
        r0_valid = 1'b0;
        vectors++; if (out_result !== 32'h8000_0001) begin miscompares++; $display("FAIL sa0_result got=%h exp=80000001", out_result); end
        r1_valid = 1'b1; r1_d = 32'h0000_1234; r1_sa = 32'd4; r1_right = 1'b0; r1_arith = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++; if (r1_ready !== 1'b0) begin miscompares++; $display("FAIL stall_ready[%0d] got=%b exp=0", i, r1_ready); end
            step();
            vectors++; if (out_result !== 32'h8000_0001) begin miscompares++; $display("FAIL stall_hold[%0d] got=%h exp=80000001", i, out_result); end
        end
        vectors++; if (busy_cnt !== 8'd5) begin miscompares++; $display("FAIL stall_busy got=%0d exp=5", busy_cnt); end
        out_ready = 1'b1;
        @(negedge clk);
        vectors++; if (r1_ready !== 1'b1) begin miscompares++; $display("FAIL stall_release_ready got=%b exp=1", r1_ready); end
        step();
        r1_valid = 1'b0;
        vectors++; if ({out_valid, out_src} !== 2'b11 || out_result !== 32'h0001_2340) begin
            miscompares++; $display("FAIL stall_release got=%b%b/%h exp=11/00012340", out_valid, out_src, out_result); end
        vectors++; if (busy_cnt !== 8'd5) begin miscompares++; $display("FAIL stall_busy_after got=%0d exp=5", busy_cnt); end
        step();
    endtask

    task automatic test_truncation();
        out_ready = 1'b1;
        r0_valid = 1'b1; r0_d = 32'h0000_0001; r0_sa = 32'h21; r0_right = 1'b0; r0_arith = 1'b1;
        @(negedge clk);
        vectors++; if (sh_sa !== 32'd1) begin miscompares++; $display("FAIL trunc_sh_sa got=%h exp=1", sh_sa); end
        step();
        r0_valid = 1'b0;
        vectors++; if (out_result !== 32'h0000_0002) begin miscompares++; $display("FAIL trunc_r0 got=%h exp=00000002", out_result); end
        r1_valid = 1'b1; r1_d = 32'h8000_0000; r1_sa = 32'hFFFF_FF3F; r1_right = 1'b1; r1_arith = 1'b0;
        step();
        r1_valid = 1'b0;
        vectors++; if (out_result !== 32'h0000_0001 || out_src !== 1'b1) begin
            miscompares++; $display("FAIL trunc_r1 got=%h/%b exp=00000001/1", out_result, out_src); end
        step();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        r0_valid = 1'b1; r0_d = 32'd5; r0_sa = 32'd1; r0_right = 1'b0; r0_arith = 1'b0;
        r1_valid = 1'b1; r1_d = 32'd7; r1_sa = 32'd1; r1_right = 1'b0; r1_arith = 1'b0;
        step();
        step();
        step();
        #2;
        clrn = 1'b0;
        #1;
        vectors++; if (out_valid !== 1'b0 || out_result !== 32'd0) begin
            miscompares++; $display("FAIL async_reset_out got=%b/%h exp=0/00000000", out_valid, out_result); end
        vectors++; if (busy_cnt !== 8'd0) begin miscompares++; $display("FAIL async_reset_busy got=%0d exp=0", busy_cnt); end
        vectors++; if ({r0_ready, r1_ready} !== 2'b00) begin miscompares++; $display("FAIL async_reset_ready got=%b exp=00", {r0_ready, r1_ready}); end
        step();
        clrn = 1'b1;
        @(negedge clk);
        vectors++; if ({r0_ready, r1_ready} !== 2'b10) begin miscompares++; $display("FAIL post_reset_gnt got=%b exp=10", {r0_ready, r1_ready}); end
        for (int i = 1; i <= 300; i++) begin
            step();
            if (i == 100) begin
                vectors++; if (busy_cnt !== 8'd99) begin miscompares++; $display("FAIL busy_mid got=%0d exp=99", busy_cnt); end
            end
        end
        vectors++; if (busy_cnt !== 8'd255) begin miscompares++; $display("FAIL busy_sat got=%0d exp=255", busy_cnt); end
        vectors++; if ({out_valid, out_src} !== 2'b10 || out_result !== 32'd10) begin
            miscompares++; $display("FAIL sat_out got=%b%b/%h exp=10/0000000a", out_valid, out_src, out_result); end
        r0_valid = 1'b0;
        r1_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_alternate();
        test_stall();
        test_truncation();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares one combinational 32-bit barrel shifter (funnel by 16/8/4/2/1, left/right, logical/arithmetic) between two requesters: requester 0 is the integer pipeline, requester 1 is the multi-cycle mul/div sequencer.
- Arbitrates with round-robin or fixed priority and drives the shifter's d/sa/right/arith inputs.
- Captures the shifter result into an output register and returns it with a source tag over a valid/ready handshake.
- One operation is accepted per cycle at most; result latency is 1 cycle.

Parameters:
- FIXED_PRIO, 0: 0 = round-robin between requesters; 1 = requester 0 always wins.
- SA_BITS, 5: number of shift-amount bits forwarded to the shifter; upper bits are ignored.

Ports:
- clk  in  1  system clock, rising edge.
- clrn  in  1  asynchronous active-low reset.
- r0_valid  in  1  requester 0 has an operation.
- r0_ready  out  1  requester 0 operation accepted this cycle.
- r0_d  in  32  requester 0 operand.
- r0_sa  in  32  requester 0 shift amount; only [SA_BITS-1:0] is used.
- r0_right  in  1  requester 0: 1 = shift right, 0 = shift left.
- r0_arith  in  1  requester 0: 1 = arithmetic (sign fill on right shift).
- r1_valid, r1_ready, r1_d, r1_sa, r1_right, r1_arith: same as requester 0, for requester 1.
- sh_d  out  32  to shifter operand.
- sh_sa  out  32  to shifter amount; upper bits are zero.
- sh_right  out  1  to shifter direction.
- sh_arith  out  1  to shifter arithmetic select.
- sh_result  in  32  from shifter, combinational.
- out_valid  out  1  result register holds an unconsumed result.
- out_ready  in  1  consumer takes the result.
- out_result  out  32  registered shift result.
- out_src  out  1  requester index that issued the result.
- busy_cnt  out  8  saturating count of cycles in which a valid request was blocked by a full output.

Behaviour:
- Reset (clrn=0, asynchronous): out_valid=0, out_result=0, out_src=0, busy_cnt=0, last_gnt=1 (requester 0 has priority first). r0_ready=r1_ready=0 while clrn=0.
- Slot free: free = !out_valid | out_ready. A result consumed in the same cycle frees the slot, so back-to-back throughput is 1 op/cycle.
- Grant, combinational:
  - Only one requester valid: it wins.
  - Both valid and FIXED_PRIO=1: requester 0 wins.
  - Both valid and FIXED_PRIO=0: the requester not equal to last_gnt wins.
  - rk_ready = free & gnt==k & rk_valid. At most one ready is high per cycle.
- Shifter drive:
  - sh_* = winner's payload; sh_sa = {zeros, rk_sa[SA_BITS-1:0]}.
  - With no valid requester, sh_* is driven from requester 0 (don't-care, no capture).
- Accept edge (rk_valid & rk_ready): out_result<=sh_result, out_src<=k, out_valid<=1. last_gnt<=k only when both requesters were valid that cycle.
- Consume without accept (out_valid & out_ready & no accept): out_valid<=0; out_result holds its value.
- Stall:
  - While out_valid & !out_ready, both readys are 0 and the output register holds.
  - busy_cnt increments by 1 on every cycle with (r0_valid|r1_valid) & !free; it saturates at 255 and never wraps.
- Requester rules: payload must be held stable while valid & !ready. A requester deasserting valid before ready is legal and is ignored.
- Reset mid-operation: a pending result is discarded and no ready is emitted until clrn returns high. The first grant after reset goes to requester 0 if both are valid.
- Arithmetic: sa≥32 in the upper bits is truncated, so sa=33 with SA_BITS=5 shifts by 1. arith with right=0 is a plain logical left shift.

Test Plan:
- r0: d=0x8000_0000, sa=4, right=1, arith=1, out_ready=1 → r0_ready the same cycle; next cycle out_valid=1, out_result=0xF800_0000, out_src=0.
- r1: d=0x0000_00FF, sa=8, left; simultaneous r0: d=0xF0, sa=4, right, logical; FIXED_PRIO=0 after reset → r0 first (0x0000_000F), then r1 (0x0000_FF00) on the following cycle, 1 op/cycle.
- Both valid continuously for 6 cycles, out_ready=1 → grants alternate 0,1,0,1,0,1. Same test with FIXED_PRIO=1 → six consecutive grants to 0, r1_ready never high.
- out_ready=0 for 5 cycles with r1_valid=1 → r1_ready=0 throughout, out_result stable, busy_cnt=5. Then out_ready=1 → old result consumed and r1 accepted in the same cycle.
- r0: sa=0x21, d=0x1, left → out_result=0x2 (truncated to 1). sa=0, right, arith, d=0x8000_0001 → 0x8000_0001.
- clrn pulsed low while out_valid=1 → out_valid=0 and busy_cnt=0 immediately (asynchronous). Hold both requesters valid for 300 stalled cycles → busy_cnt saturates at 255.
